data_mem_responder: RTL

//  Memory-side responder serving the processor's load/store port (address = ALUResult,

---
 rtl/mem_pkg.sv | 20 ++
 rtl/resp_ram.sv | 31 +++
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_pkg : shared types and constants for the data-memory responder         |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } mem_state_t;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] ERR_RDATA  = 32'h0;

endpackage

`default_nettype wire

// File: rtl/resp_ram.sv
// +----------------------------------------------------------------------------+
// | resp_ram : word-wide storage, synchronous write, combinational read        |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module resp_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_widx,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_ridx,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// +----------------------------------------------------------------------------+
// | data_mem_responder : single-outstanding load/store responder with wait     |
// |                      states and misaligned / out-of-range error flagging   |
// | Rev 1.0            : initial release                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int OB = $clog2(WORD_BYTES);
    localparam int IW = 32 - OB;
    localparam logic [IW-1:0] IDX_LIMIT = IW'(DEPTH_WORDS);

    mem_state_t     r_state;
    mem_state_t     w_next_state;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_next_cnt;
    logic           r_write;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [31:0]    r_rdata;
    logic           r_err;

    logic           w_accept;
    logic           w_enter_resp;
    logic           w_cur_write;
    logic [31:0]    w_cur_addr;
    logic [31:0]    w_cur_wdata;
    logic [IW-1:0]  w_idx;
    logic           w_err;
    logic           w_we;
    logic [31:0]    w_ram_rdata;

    // With zero wait states RESP is entered on the accepting edge, so the
    // live request must feed the array and error check instead of the latches.
    assign w_accept    = (r_state == S_IDLE) && req_valid;
    assign w_cur_write = (r_state == S_IDLE) ? req_write : r_write;
    assign w_cur_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_cur_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_idx       = w_cur_addr[31:OB];
    assign w_err       = (w_cur_addr[OB-1:0] != '0) || (w_idx >= IDX_LIMIT);
    assign w_we        = w_enter_resp && w_cur_write && !w_err && reset;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next_state = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next_state = S_WAIT;
                        w_next_cnt   = CW'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= ERR_RDATA;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_cur_write) ? ERR_RDATA : w_ram_rdata;
            end
        end
    end

    resp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_widx  (w_idx[AW-1:0]),
        .i_wdata (w_cur_wdata),
        .i_ridx  (w_idx[AW-1:0]),
        .o_rdata (w_ram_rdata)
    );

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

`default_nettype wire
